// File: rtl/settings_loader_pkg.sv
// ---------------------------------------------------------------------------
// settings_loader_pkg
// Shared types and constants for the settings loader: the published settings
// structs, the controller BRAM register map, per-group word counts and the
// loader FSM state encoding.
// ---------------------------------------------------------------------------
package settings_loader_pkg;

    // Controller BRAM register map (16-bit word addresses)
    localparam logic [7:0] ADDR_REQ       = 8'h00;
    localparam logic [7:0] ADDR_ACK       = 8'h01;
    localparam logic [7:0] ADDR_SIL_BASE  = 8'h10;
    localparam logic [7:0] ADDR_DBG_BASE  = 8'h20;
    localparam logic [7:0] ADDR_SYNC_BASE = 8'h30;

    // REQ / ACK bit positions
    localparam int REQ_BIT_SIL  = 0;
    localparam int REQ_BIT_DBG  = 1;
    localparam int REQ_BIT_SYNC = 2;

    // Words read per group
    localparam logic [3:0] NWORDS_SIL  = 4'd3;
    localparam logic [3:0] NWORDS_DBG  = 4'd8;
    localparam logic [3:0] NWORDS_SYNC = 4'd6;

    // Width of the word-index tag carried through the read pipe
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ,
        SEL,
        LOAD,
        COMMIT
    } state_e;

    typedef enum logic [1:0] {
        GRP_SIL,
        GRP_DBG,
        GRP_SYNC
    } grp_e;

    typedef struct packed {
        logic       UPDATE;
        logic       MODE;
        logic [7:0] UPDATE_RATE_INTENSITY;
        logic [7:0] UPDATE_RATE_PHASE;
        logic [7:0] COMPLETION_STEPS_INTENSITY;
        logic [7:0] COMPLETION_STEPS_PHASE;
    } silencer_settings_t;

    typedef struct packed {
        logic             UPDATE;
        logic [3:0][7:0]  DEBUG_TYPE;   // element i = TYPEi
        logic [3:0][15:0] DEBUG_VALUE;  // element i = VALUEi
    } debug_settings_t;

    typedef struct packed {
        logic        UPDATE;
        logic [31:0] ECAT_SYNC_BASE_CNT;
        logic [63:0] ECAT_SYNC_TIME;
    } sync_settings_t;

    function automatic logic [3:0] grp_nwords(input grp_e g);
        case (g)
            GRP_SIL:  grp_nwords = NWORDS_SIL;
            GRP_DBG:  grp_nwords = NWORDS_DBG;
            GRP_SYNC: grp_nwords = NWORDS_SYNC;
            default:  grp_nwords = 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] grp_base(input grp_e g);
        case (g)
            GRP_SIL:  grp_base = ADDR_SIL_BASE;
            GRP_DBG:  grp_base = ADDR_DBG_BASE;
            GRP_SYNC: grp_base = ADDR_SYNC_BASE;
            default:  grp_base = ADDR_REQ;
        endcase
    endfunction

    function automatic logic [2:0] grp_mask(input grp_e g);
        case (g)
            GRP_SIL:  grp_mask = 3'b001;
            GRP_DBG:  grp_mask = 3'b010;
            GRP_SYNC: grp_mask = 3'b100;
            default:  grp_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/settings_loader_rd_pipe.sv
// ---------------------------------------------------------------------------
// settings_loader_rd_pipe
// Delay line that follows each issued BRAM read by LATENCY cycles so the
// returning data word can be routed to the right shadow field.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (clears valid bits)
//   i_vld, i_idx   a read issued this cycle and its word index in the group
//   o_vld, o_idx   the read whose data is on BRAM_DOUT this cycle
// ---------------------------------------------------------------------------
module settings_loader_rd_pipe
    import settings_loader_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vld,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    logic [LATENCY-1:0]            r_vld;
    logic [LATENCY-1:0][IDX_W-1:0] r_idx;

    // Valid bits are cleared on reset so in-flight reads are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_vld;
            for (int k = 1; k < LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_idx[0] <= i_idx;
        for (int k = 1; k < LATENCY; k++) begin
            r_idx[k] <= r_idx[k-1];
        end
    end

    assign o_vld = r_vld[LATENCY-1];
    assign o_idx = r_idx[LATENCY-1];

endmodule

// File: rtl/settings_loader.sv
// ---------------------------------------------------------------------------
// settings_loader
// Polls the REQ word of the controller BRAM, picks one toggled group
// (silencer > debug > sync), burst-reads its registers into shadow storage
// and publishes the assembled struct with a one-cycle UPDATE strobe while
// writing the new ACK word back to the BRAM.
//
// Build option: SETTINGS_LOADER_DEBUG_EN
//   defined   - debug group is loaded and published.
//   undefined - debug toggles are acknowledged without any reads and
//               DEBUG_SETTINGS stays at its reset value.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   BRAM_ADDR           word address to the controller BRAM
//   BRAM_DOUT           read data, valid BRAM_LATENCY cycles after the address
//   BRAM_WE, BRAM_DIN   ACK write-back (only in COMMIT)
//   SILENCER_SETTINGS   published silencer settings + UPDATE
//   DEBUG_SETTINGS      published debug settings + UPDATE
//   SYNC_SETTINGS       published sync settings + UPDATE
//   BUSY                high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module settings_loader
    import settings_loader_pkg::*;
#(
    parameter int BRAM_LATENCY = 2
) (
    input  logic               CLK,
    input  logic               RST,
    output logic [7:0]         BRAM_ADDR,
    input  logic [15:0]        BRAM_DOUT,
    output logic               BRAM_WE,
    output logic [15:0]        BRAM_DIN,
    output silencer_settings_t SILENCER_SETTINGS,
    output debug_settings_t    DEBUG_SETTINGS,
    output sync_settings_t     SYNC_SETTINGS,
    output logic               BUSY
);

    localparam logic [7:0] LAST_WAIT = 8'(BRAM_LATENCY - 1);

    state_e           r_state, w_state_nxt;
    grp_e             r_grp, w_grp_nxt;
    logic [7:0]       r_wait;
    logic [3:0]       r_issue;
    logic [2:0]       r_req;
    logic [2:0]       r_ack;
    logic [2:0]       w_pend;
    logic [2:0]       w_ack_nxt;
    logic [3:0]       w_nwords;
    logic             w_issue_vld;
    logic             w_cap_vld;
    logic [IDX_W-1:0] w_cap_idx;
    logic             w_last;
    logic             w_commit;
    logic             w_req_smp;

    assign w_pend      = r_req ^ r_ack;
    assign w_nwords    = grp_nwords(r_grp);
    assign w_ack_nxt   = r_ack ^ grp_mask(r_grp);
    assign w_issue_vld = (r_state == LOAD) && (r_issue < w_nwords);
    assign w_last      = w_cap_vld && ({1'b0, w_cap_idx} == (w_nwords - 4'd1));
    assign w_commit    = (r_state == COMMIT);
    assign w_req_smp   = (r_state == WAIT_REQ) && (r_wait == LAST_WAIT);
    assign BUSY        = (r_state != IDLE);

    settings_loader_rd_pipe #(
        .LATENCY (BRAM_LATENCY)
    ) u_rd_pipe (
        .i_clk (CLK),
        .i_rst (RST),
        .i_vld (w_issue_vld),
        .i_idx (r_issue[IDX_W-1:0]),
        .o_vld (w_cap_vld),
        .o_idx (w_cap_idx)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_grp   <= GRP_SIL;
            r_wait  <= '0;
            r_issue <= '0;
            r_req   <= '0;
            r_ack   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grp   <= w_grp_nxt;
            r_wait  <= (r_state == WAIT_REQ) ? (r_wait + 8'd1) : 8'd0;
            r_issue <= (r_state == LOAD) ? (r_issue + {3'b000, w_issue_vld}) : 4'd0;
            if (w_req_smp) begin
                r_req <= BRAM_DOUT[2:0];
            end
            if (w_commit) begin
                r_ack <= w_ack_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grp_nxt   = r_grp;
        case (r_state)
            IDLE:     w_state_nxt = WAIT_REQ;
            WAIT_REQ: if (w_req_smp) w_state_nxt = SEL;
            SEL: begin
                if (w_pend[REQ_BIT_SIL]) begin
                    w_grp_nxt   = GRP_SIL;
                    w_state_nxt = LOAD;
                end else if (w_pend[REQ_BIT_DBG]) begin
                    w_grp_nxt   = GRP_DBG;
`ifdef SETTINGS_LOADER_DEBUG_EN
                    w_state_nxt = LOAD;
`else
                    // No debug datapath: acknowledge straight away.
                    w_state_nxt = COMMIT;
`endif
                end else if (w_pend[REQ_BIT_SYNC]) begin
                    w_grp_nxt   = GRP_SYNC;
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD:     if (w_last) w_state_nxt = COMMIT;
            COMMIT:   w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // BRAM port: REQ address by default, group burst in LOAD, ACK write in COMMIT
    always_comb begin
        BRAM_ADDR = ADDR_REQ;
        BRAM_WE   = 1'b0;
        BRAM_DIN  = '0;
        if (w_issue_vld) begin
            BRAM_ADDR = grp_base(r_grp) + {4'b0000, r_issue};
        end else if (w_commit) begin
            BRAM_ADDR = ADDR_ACK;
            BRAM_WE   = 1'b1;
            BRAM_DIN  = {13'b0, w_ack_nxt};
        end
    end

    // ---------------- Silencer / sync shadow and publish ----------------
    logic                    r_sh_sil_mode;
    logic [15:0]             r_sh_sil_rate;
    logic [15:0]             r_sh_sil_steps;
    logic [1:0][15:0]        r_sh_sync_base;
    logic [3:0][15:0]        r_sh_sync_time;
    silencer_settings_t      r_pub_sil, w_sil_new;
    sync_settings_t          r_pub_sync, w_sync_new;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sh_sil_mode  <= 1'b0;
            r_sh_sil_rate  <= '0;
            r_sh_sil_steps <= '0;
            r_sh_sync_base <= '0;
            r_sh_sync_time <= '0;
            r_pub_sil      <= '0;
            r_pub_sync     <= '0;
        end else begin
            if (w_cap_vld) begin
                case (r_grp)
                    GRP_SIL: begin
                        case (w_cap_idx)
                            3'd0:    r_sh_sil_mode  <= BRAM_DOUT[0];
                            3'd1:    r_sh_sil_rate  <= BRAM_DOUT;
                            3'd2:    r_sh_sil_steps <= BRAM_DOUT;
                            default: ;
                        endcase
                    end
                    GRP_SYNC: begin
                        // Words 0-1 base count, words 2-5 time (little-endian)
                        if (w_cap_idx < 3'd2) r_sh_sync_base[w_cap_idx[0]] <= BRAM_DOUT;
                        else r_sh_sync_time[2'(w_cap_idx - 3'd2)] <= BRAM_DOUT;
                    end
                    default: ;
                endcase
            end
            if (w_commit && (r_grp == GRP_SIL))  r_pub_sil  <= w_sil_new;
            if (w_commit && (r_grp == GRP_SYNC)) r_pub_sync <= w_sync_new;
        end
    end

    // During COMMIT the freshly assembled struct is presented together with
    // UPDATE; afterwards the registered copy holds it.
    always_comb begin
        w_sil_new                            = '0;
        w_sil_new.MODE                       = r_sh_sil_mode;
        w_sil_new.UPDATE_RATE_INTENSITY      = r_sh_sil_rate[7:0];
        w_sil_new.UPDATE_RATE_PHASE          = r_sh_sil_rate[15:8];
        w_sil_new.COMPLETION_STEPS_INTENSITY = r_sh_sil_steps[7:0];
        w_sil_new.COMPLETION_STEPS_PHASE     = r_sh_sil_steps[15:8];
        SILENCER_SETTINGS = r_pub_sil;
        if (w_commit && (r_grp == GRP_SIL)) begin
            SILENCER_SETTINGS        = w_sil_new;
            SILENCER_SETTINGS.UPDATE = 1'b1;
        end
    end

    always_comb begin
        w_sync_new                    = '0;
        w_sync_new.ECAT_SYNC_BASE_CNT = r_sh_sync_base;
        w_sync_new.ECAT_SYNC_TIME     = r_sh_sync_time;
        SYNC_SETTINGS = r_pub_sync;
        if (w_commit && (r_grp == GRP_SYNC)) begin
            SYNC_SETTINGS        = w_sync_new;
            SYNC_SETTINGS.UPDATE = 1'b1;
        end
    end

    // ---------------- Debug shadow and publish ----------------
`ifdef SETTINGS_LOADER_DEBUG_EN
    logic [3:0][7:0]  r_sh_dbg_type;
    logic [3:0][15:0] r_sh_dbg_val;
    debug_settings_t  r_pub_dbg, w_dbg_new;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sh_dbg_type <= '0;
            r_sh_dbg_val  <= '0;
            r_pub_dbg     <= '0;
        end else begin
            // Words 0-3 are TYPE (low byte only), words 4-7 are VALUE
            if (w_cap_vld && (r_grp == GRP_DBG)) begin
                if (!w_cap_idx[2]) r_sh_dbg_type[w_cap_idx[1:0]] <= BRAM_DOUT[7:0];
                else r_sh_dbg_val[w_cap_idx[1:0]] <= BRAM_DOUT;
            end
            if (w_commit && (r_grp == GRP_DBG)) r_pub_dbg <= w_dbg_new;
        end
    end

    always_comb begin
        w_dbg_new             = '0;
        w_dbg_new.DEBUG_TYPE  = r_sh_dbg_type;
        w_dbg_new.DEBUG_VALUE = r_sh_dbg_val;
        DEBUG_SETTINGS = r_pub_dbg;
        if (w_commit && (r_grp == GRP_DBG)) begin
            DEBUG_SETTINGS        = w_dbg_new;
            DEBUG_SETTINGS.UPDATE = 1'b1;
        end
    end
`else
    assign DEBUG_SETTINGS = '0;
`endif

endmodule
